// File: rtl/hdlc_rx_drain.sv
// Drains complete frames out of an HDLC controller's receive buffer into a byte stream.
// Optional build macro HDLC_RX_DRAIN_STATS_EN adds saturating frame_cnt/err_cnt outputs.
module hdlc_rx_drain #(
    parameter int MAX_LEN  = 126,
    parameter int POLL_GAP = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx_Ready,
    output logic [2:0] Address,
    output logic       WriteEnable,
    output logic       ReadEnable,
    output logic [7:0] DataIn,
    input  logic [7:0] DataOut,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       m_err
`ifdef HDLC_RX_DRAIN_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam logic [2:0] ADDR_SC   = 3'd2;
    localparam logic [2:0] ADDR_BUFF = 3'd3;
    localparam logic [2:0] ADDR_LEN  = 3'd4;
    localparam logic [7:0] DROP_CMD  = 8'h02;
    localparam logic [7:0] LEN_ERR   = 8'hFF;
    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);
    localparam int         GAP_LAST  = (POLL_GAP > 1) ? POLL_GAP - 1 : 0;
    localparam int         GW        = $clog2(GAP_LAST + 2);

    typedef enum logic [2:0] {
        IDLE,
        RD_SC,
        RD_LEN,
        RD_BYTE,
        PUSH,
        ERR_PUSH,
        DROP,
        GAP
    } state_e;

    state_e          state_q, state_d;
    logic            phase_q, phase_d;   // 0: issue read strobe, 1: capture DataOut
    logic [7:0]      data_q,  data_d;
    logic [7:0]      cnt_q,   cnt_d;
    logic [GW-1:0]   gap_q,   gap_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            data_q  <= 8'h00;
            cnt_q   <= 8'h00;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        phase_d     = 1'b0;
        data_d      = data_q;
        cnt_d       = cnt_q;
        gap_d       = '0;
        Address     = 3'd0;
        WriteEnable = 1'b0;
        ReadEnable  = 1'b0;
        DataIn      = 8'h00;
        m_valid     = 1'b0;
        m_data      = 8'h00;
        m_last      = 1'b0;
        m_err       = 1'b0;

        case (state_q)
            IDLE: begin
                if (Rx_Ready) state_d = RD_SC;
            end
            RD_SC: begin
                if (!phase_q) begin
                    ReadEnable = 1'b1;
                    Address    = ADDR_SC;
                    phase_d    = 1'b1;
                end else begin
                    data_d  = DataOut;
                    state_d = (|DataOut[4:2]) ? ERR_PUSH : RD_LEN;
                end
            end
            RD_LEN: begin
                if (!phase_q) begin
                    ReadEnable = 1'b1;
                    Address    = ADDR_LEN;
                    phase_d    = 1'b1;
                end else if ((DataOut == 8'h00) || ({1'b0, DataOut} > MAX_LEN_W)) begin
                    data_d  = LEN_ERR;
                    state_d = ERR_PUSH;
                end else begin
                    cnt_d   = DataOut;
                    state_d = RD_BYTE;
                end
            end
            RD_BYTE: begin
                if (!phase_q) begin
                    ReadEnable = 1'b1;
                    Address    = ADDR_BUFF;
                    phase_d    = 1'b1;
                end else begin
                    data_d  = DataOut;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                // Next Rx_Buff read waits for this handshake: one byte in flight.
                m_valid = 1'b1;
                m_data  = data_q;
                m_last  = (cnt_q == 8'd1);
                if (m_ready) begin
                    cnt_d   = cnt_q - 8'd1;
                    state_d = (cnt_q == 8'd1) ? GAP : RD_BYTE;
                end
            end
            ERR_PUSH: begin
                m_valid = 1'b1;
                m_err   = 1'b1;
                m_last  = 1'b1;
                m_data  = data_q;
                if (m_ready) state_d = DROP;
            end
            DROP: begin
                WriteEnable = 1'b1;
                Address     = ADDR_SC;
                DataIn      = DROP_CMD;
                state_d     = GAP;
            end
            GAP: begin
                // Hold off so a Rx_Ready that the HDLC has not yet cleared is not re-sampled.
                if (gap_q == GW'(GAP_LAST)) state_d = IDLE;
                else                        gap_d   = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef HDLC_RX_DRAIN_STATS_EN
    logic        frame_hs, err_hs;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q,   err_cnt_d;

    assign frame_hs = (state_q == PUSH) && m_ready && (cnt_q == 8'd1);
    assign err_hs   = (state_q == ERR_PUSH) && m_ready;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (frame_hs && (frame_cnt_q != 16'hFFFF)) frame_cnt_d = frame_cnt_q + 16'd1;
        if (err_hs   && (err_cnt_q   != 16'hFFFF)) err_cnt_d   = err_cnt_q + 16'd1;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            frame_cnt_q <= 16'h0000;
            err_cnt_q   <= 16'h0000;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: doc/hdlc_rx_drain.md
HDLC_RX_DRAIN -- requirements
Module: hdlc_rx_drain

Interface
REQ-001 SHALL have parameter MAX_LEN, default 126, maximum accepted frame length in bytes.
REQ-002 SHALL have parameter POLL_GAP, default 4, idle cycles between consecutive status polls.
REQ-003 SHALL have port Clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Rx_Ready  input  1  HDLC receive buffer holds a complete frame.
REQ-006 SHALL have port Address  output  3  HDLC register address.
REQ-007 SHALL have port WriteEnable  output  1  HDLC register write strobe.
REQ-008 SHALL have port ReadEnable  output  1  HDLC register read strobe.
REQ-009 SHALL have port DataIn  output  8  write data to HDLC.
REQ-010 SHALL have port DataOut  input  8  read data from HDLC, valid one cycle after ReadEnable.
REQ-011 SHALL have port m_valid  output  1  output byte stream valid.
REQ-012 SHALL have port m_ready  input  1  downstream accepts byte.
REQ-013 SHALL have port m_data  output  8  frame byte, or status byte on error beat.
REQ-014 SHALL have port m_last  output  1  final beat of frame.
REQ-015 SHALL have port m_err  output  1  beat reports a rejected frame.

Function
REQ-016 SHALL use HDLC register map: 2 = Rx_SC, 3 = Rx_Buff, 4 = Rx_Len; Rx_SC bit1 Drop, bit2 FrameError, bit3 Abort, bit4 Overflow.
REQ-017 SHALL implement FSM IDLE, RD_SC, RD_LEN, RD_BYTE, PUSH, ERR_PUSH, DROP, GAP.
REQ-018 IDLE: when Rx_Ready = 1 SHALL go to RD_SC; otherwise stay.
REQ-019 Each RD_* state SHALL assert ReadEnable for exactly one cycle with the matching Address and capture DataOut on the following cycle.
REQ-020 RD_SC: any of bits 2..4 set SHALL go to ERR_PUSH; else go to RD_LEN.
REQ-021 RD_LEN: length 0 or > MAX_LEN SHALL go to ERR_PUSH with m_data = 8'hFF; else load the byte counter and go to RD_BYTE.
REQ-022 RD_BYTE -> PUSH: m_valid = 1, m_data = captured byte, m_last = 1 only when the counter reaches 1.
REQ-023 PUSH SHALL hold m_data/m_last stable while m_valid = 1 and m_ready = 0; on handshake decrement the counter, then go to RD_BYTE, or to GAP after the last byte.
REQ-024 SHALL not issue the next Rx_Buff read before the current byte has been accepted (no prefetch; one byte in flight).
REQ-025 ERR_PUSH SHALL present one beat (m_err = 1, m_last = 1, m_data = status byte or 8'hFF), then go to DROP after the handshake.
REQ-026 DROP SHALL assert WriteEnable for one cycle with Address = 2 and DataIn = 8'h02, then go to GAP.
REQ-027 GAP SHALL wait POLL_GAP cycles, then return to IDLE, so a Rx_Ready still stale from the HDLC is not re-sampled.
REQ-028 ReadEnable and WriteEnable SHALL never both be asserted; Address and DataIn SHALL be 0 when neither strobe is asserted.
REQ-029 Rx_Ready deasserting mid-frame SHALL be ignored; the latched length is drained to completion.
REQ-030 m_err SHALL be 0 on every data beat.

Reset
REQ-031 Rst = 0 SHALL immediately force: FSM to IDLE, counters to 0, and all outputs (Address, WriteEnable, ReadEnable, DataIn, m_valid, m_data, m_last, m_err) to 0.
REQ-032 Reset during PUSH SHALL discard the beat; after reset, the next frame SHALL start with a fresh Rx_SC poll.

Configuration
REQ-033 With macro HDLC_RX_DRAIN_STATS_EN defined, the block SHALL add outputs frame_cnt (16) and err_cnt (16), saturating at 16'hFFFF, reset to 0.
REQ-034 frame_cnt SHALL increment on each data handshake where m_last = 1; err_cnt SHALL increment on each ERR_PUSH handshake.
REQ-035 Without HDLC_RX_DRAIN_STATS_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Verification
REQ-036 Rx_Ready = 1, Rx_SC = 8'h01, Rx_Len = 3, bytes A5 5A 3C, m_ready = 1 -> three beats A5, 5A, 3C; m_last only on 3C; m_err = 0.
REQ-037 Same frame, m_ready toggled 1 of every 3 cycles -> identical beat sequence, m_data stable while stalled, exactly 3 Rx_Buff reads.
REQ-038 Rx_SC = 8'h09 (abort) -> one beat m_err = 1, m_last = 1, m_data = 8'h09; then write Address 2 / DataIn 8'h02; no Rx_Buff reads.
REQ-039 Rx_Len = 127 with MAX_LEN = 126 -> error beat m_data = 8'hFF, followed by the Drop write.
REQ-040 Rst pulsed low during the second beat of a 3-byte frame -> all outputs 0 immediately; after release, a new frame restarts with an Rx_SC read.
REQ-041 With HDLC_RX_DRAIN_STATS_EN defined: two good frames and one aborted frame -> frame_cnt = 2, err_cnt = 1.
